// File: rtl/rst_sequencer.sv
// Clock/reset supervisor: holds the PLL in reset, waits for stable lock, then
// releases subsystem resets one at a time; re-resets the PLL on lock loss.
module rst_sequencer #(
    parameter int unsigned N_STAGES           = 4,
    parameter int unsigned SYNC_N             = 2,
    parameter int unsigned PLL_RST_CYCLES     = 8,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned CNT_WIDTH          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 sw_reset,
    output logic                 pll_rst,
    output logic [N_STAGES-1:0]  stage_rst,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] lock_loss_count,
    output logic [CNT_WIDTH-1:0] timeout_count
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                         max2(STAGE_DELAY, LOCK_TIMEOUT));
    localparam int unsigned TW = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [TW-1:0] PLL_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STAGE_LAST   = TW'(STAGE_DELAY - 1);

    localparam logic [N_STAGES-1:0] FIRST_REL  = ~N_STAGES'(1);
    localparam logic [N_STAGES-1:0] LAST_STAGE = N_STAGES'(1) << (N_STAGES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [SYNC_N-1:0]   sync_q;
    logic                locked_s;

    assign locked_s = sync_q[SYNC_N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_PLL_RST;
            timer           <= '0;
            sync_q          <= '0;
            pll_rst         <= 1'b1;
            stage_rst       <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
            timeout_count   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pll_locked};
            case (state)
                S_PLL_RST: begin
                    if (timer == PLL_LAST) begin
                        state   <= S_WAIT_LOCK;
                        pll_rst <= 1'b0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state   <= S_PLL_RST;
                        pll_rst <= 1'b1;
                        timer   <= '0;
                        if (timeout_count != '1)
                            timeout_count <= timeout_count + CNT_WIDTH'(1);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (sw_reset) begin
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        timer <= '0;
                        // A single stage goes straight to RUN together with its release.
                        if (N_STAGES == 1) begin
                            stage_rst <= '0;
                            ready     <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            stage_rst <= FIRST_REL;
                            state     <= S_RELEASE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_PLL_RST;
                        pll_rst   <= 1'b1;
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        timer     <= '0;
                        if (lock_loss_count != '1)
                            lock_loss_count <= lock_loss_count + CNT_WIDTH'(1);
                    end else if (sw_reset) begin
                        state     <= S_STABLE;
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        timer     <= '0;
                    end else if (state == S_RELEASE) begin
                        if (timer == STAGE_LAST) begin
                            timer     <= '0;
                            stage_rst <= stage_rst << 1;
                            if (stage_rst == LAST_STAGE) begin
                                ready <= 1'b1;
                                state <= S_RUN;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: begin
                    state     <= S_PLL_RST;
                    pll_rst   <= 1'b1;
                    stage_rst <= '1;
                    ready     <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed scenarios plus random
// lock/soft-reset activity, compared against a phase/elapsed-time model.
module tb_rst_sequencer;

    localparam int unsigned N    = 3;
    localparam int unsigned SN   = 2;
    localparam int unsigned PC   = 4;
    localparam int unsigned LS   = 8;
    localparam int unsigned SD   = 4;
    localparam int unsigned TO   = 32;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam int unsigned OW   = N + 2 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_reset = 1'b0;
    logic          pll_rst;
    logic [N-1:0]  stage_rst;
    logic          ready;
    logic [CW-1:0] lock_loss_count;
    logic [CW-1:0] timeout_count;

    int checks = 0;
    int failures = 0;

    rst_sequencer #(
        .N_STAGES(N), .SYNC_N(SN), .PLL_RST_CYCLES(PC), .LOCK_STABLE_CYCLES(LS),
        .STAGE_DELAY(SD), .LOCK_TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_reset(sw_reset),
        .pll_rst(pll_rst), .stage_rst(stage_rst), .ready(ready),
        .lock_loss_count(lock_loss_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Model: a phase plus cycles elapsed in it; PH_UP covers staggered release and run.
    typedef enum {PH_PLL, PH_WAIT, PH_STAB, PH_UP} phase_t;
    phase_t      ph = PH_PLL;
    int unsigned t = 0;
    int unsigned m_llc = 0;
    int unsigned m_tc = 0;
    bit          lq[$];

    task automatic model_edge();
        bit ls;
        if (rst) begin
            ph = PH_PLL; t = 0; m_llc = 0; m_tc = 0;
            lq.delete();
            repeat (SN) lq.push_back(1'b0);
            return;
        end
        ls = lq.pop_front();
        lq.push_back(pll_locked);
        case (ph)
            PH_PLL: if (t + 1 == PC) begin ph = PH_WAIT; t = 0; end else t++;
            PH_WAIT: begin
                if (ls) begin ph = PH_STAB; t = 0; end
                else if (t + 1 == TO) begin ph = PH_PLL; t = 0; if (m_tc < CMAX) m_tc++; end
                else t++;
            end
            PH_STAB: begin
                if (!ls) begin ph = PH_WAIT; t = 0; end
                else if (sw_reset) t = 0;
                else if (t + 1 == LS) begin ph = PH_UP; t = 0; end
                else t++;
            end
            PH_UP: begin
                if (!ls) begin ph = PH_PLL; t = 0; if (m_llc < CMAX) m_llc++; end
                else if (sw_reset) begin ph = PH_STAB; t = 0; end
                else if (t < N * SD) t++;
            end
        endcase
    endtask

    function automatic logic [OW-1:0] model_out();
        int unsigned rel;
        logic [N-1:0] st;
        logic rdy;
        st = '1;
        rdy = 1'b0;
        if (ph == PH_UP) begin
            rel = t / SD + 1;
            if (rel > N) rel = N;
            st = N'(((1 << N) - 1) & ~((1 << rel) - 1));
            rdy = (rel == N);
        end
        return {ph == PH_PLL, st, rdy, CW'(m_llc), CW'(m_tc)};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {pll_rst, stage_rst, ready, lock_loss_count, timeout_count};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; sw_reset = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (dut_out() !== {1'b1, 3'b111, 1'b0, 2'd0, 2'd0}) begin
            failures++;
            $display("FAIL reset_state dut=%b required=%b", dut_out(), {1'b1, 3'b111, 1'b0, 2'd0, 2'd0});
        end
    endtask

    task automatic test_power_up();
        int pll_hi = 0;
        int first_ready = -1;
        logic [N-1:0] st13 = '0, st17 = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL power_up cyc=%0d dut=%b model=%b", i, dut_out(), model_out());
            end
            if (pll_rst === 1'b1) pll_hi++;
            if (ready === 1'b1 && first_ready < 0) first_ready = i;
            if (i == 13) st13 = stage_rst;
            if (i == 17) st17 = stage_rst;
        end
        checks++;
        if (pll_hi != PC - 1) begin failures++; $display("FAIL pll_rst_width extra_high=%0d required=%0d", pll_hi, PC - 1); end
        checks++;
        if (first_ready != 21) begin failures++; $display("FAIL ready_time cyc=%0d required=21", first_ready); end
        checks++;
        if (st13 !== 3'b110) begin failures++; $display("FAIL stage0_release dut=%b required=110", st13); end
        checks++;
        if (st17 !== 3'b100) begin failures++; $display("FAIL stage1_release dut=%b required=100", st17); end
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL lock_loss cyc=%0d dut=%b model=%b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (lock_loss_count !== 2'd1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL lock_loss_end count=%0d ready=%b required count=1 ready=1", lock_loss_count, ready);
        end
    endtask

    task automatic test_timeout();
        pll_locked = 1'b0;
        for (int i = 0; i < 4 * (PC + TO) + 10; i++) begin
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL timeout cyc=%0d dut=%b model=%b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (timeout_count !== 2'd3 || lock_loss_count !== 2'd2) begin
            failures++;
            $display("FAIL timeout_saturate tc=%0d llc=%0d required tc=3 llc=2", timeout_count, lock_loss_count);
        end
    endtask

    task automatic test_stable_glitch();
        int k = 0;
        pll_locked = 1'b1;
        while (!(ph == PH_STAB && t == 4) && k < 200) begin
            step(); k++;
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL glitch_wait cyc=%0d dut=%b model=%b", k, dut_out(), model_out());
            end
        end
        checks++;
        if (!(ph == PH_STAB && t == 4)) begin failures++; $display("FAIL glitch_reach_stable waited=%0d required<200", k); end
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (stage_rst !== 3'b111 || dut_out() !== model_out()) begin
                failures++;
                $display("FAIL glitch_hold cyc=%0d dut=%b model=%b stage_required=111", i, dut_out(), model_out());
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL glitch_relock cyc=%0d dut=%b model=%b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ready !== 1'b1 || lock_loss_count !== 2'd2 || timeout_count !== 2'd3) begin
            failures++;
            $display("FAIL glitch_counters ready=%b llc=%0d tc=%0d required 1/2/3", ready, lock_loss_count, timeout_count);
        end
    endtask

    task automatic test_sw_reset();
        int k = 0;
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        checks++;
        if (stage_rst !== 3'b111 || pll_rst !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL sw_reset_assert stage=%b pll_rst=%b ready=%b required 111/0/0", stage_rst, pll_rst, ready);
        end
        while (ready !== 1'b1 && k < 40) begin
            step(); k++;
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL sw_reset_resume cyc=%0d dut=%b model=%b", k, dut_out(), model_out());
            end
        end
        checks++;
        if (k != LS + (N - 1) * SD) begin failures++; $display("FAIL sw_reset_latency cyc=%0d required=%0d", k, LS + (N - 1) * SD); end
        // Drop lock two edges early so it reaches the FSM together with sw_reset.
        pll_locked = 1'b0;
        step(); step();
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        checks++;
        if (pll_rst !== 1'b1 || lock_loss_count !== 2'd3 || dut_out() !== model_out()) begin
            failures++;
            $display("FAIL sw_and_loss pll_rst=%b llc=%0d dut=%b model=%b required pll_rst=1 llc=3",
                     pll_rst, lock_loss_count, dut_out(), model_out());
        end
    endtask

    task automatic test_mid_release_reset();
        int k = 0;
        pll_locked = 1'b1;
        while (!(ph == PH_UP && t == SD) && k < 100) begin
            step(); k++;
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL mid_release_wait cyc=%0d dut=%b model=%b", k, dut_out(), model_out());
            end
        end
        checks++;
        if (stage_rst !== 3'b100) begin failures++; $display("FAIL mid_release_stage dut=%b required=100", stage_rst); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dut_out() !== {1'b1, 3'b111, 1'b0, 2'd0, 2'd0}) begin
            failures++;
            $display("FAIL mid_release_reset dut=%b required=%b", dut_out(), {1'b1, 3'b111, 1'b0, 2'd0, 2'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) pll_locked = ~pll_locked;
            sw_reset = ($urandom_range(49) == 0);
            rst = ($urandom_range(599) == 0);
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL random cyc=%0d dut=%b model=%b", i, dut_out(), model_out());
            end
        end
        rst = 1'b0;
        sw_reset = 1'b0;
    endtask

    initial begin
        repeat (SN) lq.push_back(1'b0);
        test_reset();
        test_power_up();
        test_lock_loss();
        test_timeout();
        test_stable_glitch();
        test_sw_reset();
        test_mid_release_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
